// File: rtl/nibsort_pkg.sv
// Shared types, default sizes and the key-ordering comparator for the nibble stream sorter.
// Define NIBBLE_SORT_DESCENDING_EN for descending order; the default build sorts ascending.
package nibsort_pkg;

  typedef enum logic {FILL, DRAIN} nibsort_state_e;

  localparam int DEF_W = 4;
  localparam int DEF_N = 4;

  // True when key a must be placed strictly ahead of key b; equal keys never
  // reorder, so a later arrival always lands behind earlier equal keys.
  function automatic logic key_before(input logic [31:0] a, input logic [31:0] b);
`ifdef NIBBLE_SORT_DESCENDING_EN
    return a > b;
`else
    return a < b;
`endif
  endfunction

endpackage

// File: rtl/nibble_stream_sorter_if.sv
// Input and output key streams of the nibble stream sorter, bundled with master/slave views.
interface nibble_stream_sorter_if #(
  parameter int W = 4,
  parameter int N = 4
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [N*W-1:0] out_word;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, out_word
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_word
  );
endinterface

// File: rtl/nibsort_slot.sv
// One sorted-buffer slot: holds, takes the incoming key, or shifts in its left neighbour.
module nibsort_slot
  import nibsort_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter bit IS_FIRST = 1'b0
) (
  input  logic [W-1:0] i_new_key,
  input  logic [W-1:0] i_left_key,
  input  logic [W-1:0] i_own_key,
  input  logic         i_enable,
  input  logic         i_own_used,
  output logic [W-1:0] o_next_key
);

  logic w_before_own;
  logic w_before_left;

  // An empty slot behaves as if it held a key that sorts after everything.
  assign w_before_own  = !i_own_used || key_before(32'(i_new_key), 32'(i_own_key));
  assign w_before_left = !IS_FIRST && key_before(32'(i_new_key), 32'(i_left_key));

  always_comb begin
    o_next_key = i_own_key;
    if (i_enable) begin
      if (w_before_left) begin
        o_next_key = i_left_key;
      end else if (w_before_own) begin
        o_next_key = i_new_key;
      end
    end
  end

endmodule

// File: rtl/nibble_stream_sorter.sv
// Serial insertion sorter: fills N keys, then drains them in order one per handshake.
// Sort direction follows NIBBLE_SORT_DESCENDING_EN (see nibsort_pkg).
module nibble_stream_sorter
  import nibsort_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_flush,
  nibble_stream_sorter_if.slave  bus
);

  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  nibsort_state_e r_state;
  nibsort_state_e w_state_next;
  logic [CW-1:0]  r_wr_cnt;
  logic [CW-1:0]  r_rd_idx;
  logic [W-1:0]   r_buf      [N];
  logic [W-1:0]   w_buf_next [N];
  logic           w_accept;
  logic           w_handshake;
  logic           w_wr_last;
  logic           w_rd_last;

  assign w_accept    = bus.in_valid && (r_state == FILL);
  assign w_handshake = bus.out_ready && (r_state == DRAIN);
  assign w_wr_last   = (r_wr_cnt == LAST);
  assign w_rd_last   = (r_rd_idx == LAST);

  // Only slots 0..wr_cnt take part in an insertion; slots at or above wr_cnt are empty.
  for (genvar j = 0; j < N; j++) begin : g_slot
    logic         w_enable;
    logic         w_used;
    logic [W-1:0] w_left;

    assign w_enable = w_accept && (CW'(j) <= r_wr_cnt);
    assign w_used   = (CW'(j) < r_wr_cnt);

    if (j == 0) begin : g_first
      assign w_left = '0;
    end else begin : g_rest
      assign w_left = r_buf[j-1];
    end

    nibsort_slot #(
      .W        (W),
      .IS_FIRST (j == 0)
    ) u_slot (
      .i_new_key  (bus.in_data),
      .i_left_key (w_left),
      .i_own_key  (r_buf[j]),
      .i_enable   (w_enable),
      .i_own_used (w_used),
      .o_next_key (w_buf_next[j])
    );
  end

  always_comb begin
    w_state_next = r_state;
    if (i_flush) begin
      w_state_next = FILL;
    end else begin
      case (r_state)
        FILL:    if (w_accept && w_wr_last)    w_state_next = DRAIN;
        DRAIN:   if (w_handshake && w_rd_last) w_state_next = FILL;
        default: w_state_next = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flush beats a same-cycle accept or handshake, so that key is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_cnt <= '0;
      r_rd_idx <= '0;
      for (int k = 0; k < N; k++) r_buf[k] <= '0;
    end else if (i_flush) begin
      r_wr_cnt <= '0;
      r_rd_idx <= '0;
    end else begin
      if (w_accept) begin
        r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + CW'(1);
        for (int k = 0; k < N; k++) r_buf[k] <= w_buf_next[k];
      end
      if (w_handshake) begin
        r_rd_idx <= w_rd_last ? '0 : r_rd_idx + CW'(1);
      end
    end
  end

  assign bus.in_ready  = (r_state == FILL);
  assign bus.out_valid = (r_state == DRAIN);

  always_comb begin
    bus.out_data = '0;
    bus.out_last = 1'b0;
    bus.out_word = '0;
    if (r_state == DRAIN) begin
      bus.out_data = r_buf[r_rd_idx];
      bus.out_last = w_rd_last;
      for (int k = 0; k < N; k++) bus.out_word[k*W +: W] = r_buf[k];
    end
  end

endmodule

// File: tb/tb_nibble_stream_sorter.sv
// Directed self-checking bench for nibble_stream_sorter (W=4, N=4), both sort directions.
module tb_nibble_stream_sorter;

  localparam int W = 4;
  localparam int N = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  nibble_stream_sorter_if #(.W(W), .N(N)) bus ();

  nibble_stream_sorter #(.W(W), .N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .bus     (bus)
  );

  // Hand-computed sorted frames (key k of the frame at [4k+:4]).
`ifdef NIBBLE_SORT_DESCENDING_EN
  localparam logic [15:0] EXP_T1 = 16'h1134;
  localparam logic [15:0] EXP_T3 = 16'h0279;
  localparam logic [15:0] EXP_T4 = 16'h2345;
  localparam logic [15:0] EXP_T5 = 16'hABCD;
`else
  localparam logic [15:0] EXP_T1 = 16'h4311;
  localparam logic [15:0] EXP_T3 = 16'h9720;
  localparam logic [15:0] EXP_T4 = 16'h5432;
  localparam logic [15:0] EXP_T5 = 16'hDCBA;
`endif

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
    checkOutput({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
    checkOutput({tag, ".out_last"},  32'(bus.out_last),  32'd0);
    checkOutput({tag, ".out_data"},  32'(bus.out_data),  32'd0);
    checkOutput({tag, ".out_word"},  32'(bus.out_word),  32'd0);
  endtask

  // Sends a full frame back to back; first key sits in keys[3:0].
  task automatic applyStimulus(input string tag, input logic [15:0] keys);
    for (int i = 0; i < N; i++) begin
      checkOutput({tag, ".fill_ready"}, 32'(bus.in_ready),  32'd1);
      checkOutput({tag, ".fill_valid"}, 32'(bus.out_valid), 32'd0);
      bus.in_valid = 1'b1;
      bus.in_data  = keys[i*4 +: 4];
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    checkOutput({tag, ".latency"}, 32'(bus.out_valid), 32'd1);
  endtask

  // out_ready on drain cycle c is readyPat[c % 8]; every cycle checks the held key.
  task automatic drainFrame(input string tag, input logic [15:0] expWord, input logic [7:0] readyPat);
    int k = 0;
    int c = 0;
    while (k < N && c < 40) begin
      bus.out_ready = readyPat[c % 8];
      checkOutput({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
      checkOutput({tag, ".data"},  32'(bus.out_data),  32'(expWord[k*4 +: 4]));
      checkOutput({tag, ".last"},  32'(bus.out_last),  32'(k == N - 1));
      checkOutput({tag, ".word"},  32'(bus.out_word),  32'(expWord));
      if (bus.out_ready) k++;
      c++;
      tick();
    end
    bus.out_ready = 1'b0;
    checkOutput({tag, ".drained"}, 32'(k), 32'(N));
    checkIdle({tag, ".after"});
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #2;
    checkIdle("reset");
    rst_n = 1'b1;
    tick();
    checkIdle("post_reset");

    applyStimulus("t1", 16'h1413);
    drainFrame("t1", EXP_T1, 8'hFF);

    applyStimulus("t2", 16'hFFFF);
    drainFrame("t2", 16'hFFFF, 8'hFF);

    applyStimulus("t3", 16'h7290);
    drainFrame("t3", EXP_T3, 8'b1111_1001);

    // Two keys, then a flush that also discards a simultaneously offered key.
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = (i == 0) ? 4'h8 : 4'h6;
      tick();
    end
    flush        = 1'b1;
    bus.in_data  = 4'h0;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    checkIdle("t4_flush_fill");
    applyStimulus("t4", 16'h2345);
    drainFrame("t4", EXP_T4, 8'hFF);

    // Flush while draining at rd_idx=1.
    applyStimulus("t4d", 16'h2345);
    bus.out_ready = 1'b1;
    checkOutput("t4d.data0", 32'(bus.out_data), 32'(EXP_T4[3:0]));
    tick();
    bus.out_ready = 1'b0;
    checkOutput("t4d.data1", 32'(bus.out_data), 32'(EXP_T4[7:4]));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkIdle("t4d_flush_drain");

    // Asynchronous reset pulse between edges while draining.
    applyStimulus("t5a", 16'h6789);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkIdle("t5_async_reset");
    rst_n = 1'b1;
    tick();
    checkIdle("t5_released");
    applyStimulus("t5", 16'hDBAC);
    drainFrame("t5", EXP_T5, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
